cv32e40p_ft_error_monitor: RTL

- Sequential collector for the error flags driven by the core's triple-redundant units and their 3-way voters.
- One monitor receives the per-unit correct/detect pairs. It keeps saturating corrected-error counters per unit and flags suspected permanent faults, using a burst threshold inside a fixed time window.
- Latches uncorrectable events, raises an interrupt, and exposes counters through a simple request/grant read port for debug or CSR access.

---
 rtl/cv32e40p_ft_error_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cv32e40p_ft_error_monitor.sv
// Error monitor for the triple-redundant units and their 3-way voters.
// Per unit it keeps a saturating corrected-error counter and a burst counter
// that is reset every WINDOW cycles. The burst counter flags suspected
// permanent faults.
// It latches uncorrectable events into sticky flags and registers an
// interrupt from them. Counters are read through a two-state request/grant port.
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   error_correct_i / error_detected_i    per-unit voter flags
//   rd_req_i, rd_addr_i, rd_clr_i         read request, unit index, clear-on-read
//   rd_gnt_o, rd_valid_o, rd_data_o       grant, 1-cycle data valid, counter value
//   sticky_clr_i                          clears perm_fault_o and uncorr_o
//   perm_fault_o, uncorr_o, irq_o         sticky flags and registered interrupt
module cv32e40p_ft_error_monitor #(
  parameter int NUM_UNITS   = 8,
  parameter int CNT_W       = 16,
  parameter int PERM_THRESH = 4,
  parameter int WINDOW      = 256,
  parameter int ADDR_W      = $clog2(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_UNITS-1:0] error_correct_i,
  input  logic [NUM_UNITS-1:0] error_detected_i,
  input  logic                 rd_req_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  input  logic                 rd_clr_i,
  output logic                 rd_gnt_o,
  output logic                 rd_valid_o,
  output logic [CNT_W-1:0]     rd_data_o,
  input  logic                 sticky_clr_i,
  output logic [NUM_UNITS-1:0] perm_fault_o,
  output logic                 uncorr_o,
  output logic                 irq_o
);

  localparam int               WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [7:0]       THRESH   = 8'(PERM_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state_q, state_d;
  logic [WIN_W-1:0]     win_q;
  logic                 win_last;
  logic [CNT_W-1:0]     cnt_q   [NUM_UNITS];
  logic [7:0]           burst_q [NUM_UNITS];
  logic [NUM_UNITS-1:0] perm_set;
  logic [NUM_UNITS-1:0] clr_hit;
  logic                 uncorr_any;
  logic                 addr_ok;

  assign win_last   = (win_q == WIN_LAST);
  assign uncorr_any = |(error_detected_i & ~error_correct_i);
  // The address port may be wider than the unit count; such reads return 0.
  assign addr_ok    = (32'(rd_addr_i) < 32'(NUM_UNITS));

  // Read FSM: grant is combinational in IDLE, RESP blocks new requests.
  always_comb begin
    state_d    = state_q;
    rd_gnt_o   = 1'b0;
    rd_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        rd_gnt_o = rd_req_i;
        if (rd_req_i) state_d = RESP;
      end
      RESP: begin
        rd_valid_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Perm-fault set uses the incremented burst value. A corr event that lands
  // on the last window cycle never contributes to a burst.
  always_comb begin
    perm_set = '0;
    clr_hit  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      perm_set[u] = error_correct_i[u] && !win_last &&
                    ((burst_q[u] + 8'd1) == THRESH);
      clr_hit[u]  = rd_gnt_o && rd_clr_i && addr_ok &&
                    (rd_addr_i == ADDR_W'(u));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (win_last) begin
      win_q <= '0;
    end else begin
      win_q <= win_q + WIN_W'(1);
    end
  end

  // Clear-on-read restarts the counter from this cycle's event, so no
  // event is lost between the captured value and the cleared counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        cnt_q[u]   <= '0;
        burst_q[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (clr_hit[u]) begin
          cnt_q[u] <= CNT_W'(error_correct_i[u]);
        end else if (error_correct_i[u] && (cnt_q[u] != CNT_MAX)) begin
          cnt_q[u] <= cnt_q[u] + CNT_W'(1);
        end

        if (win_last) begin
          burst_q[u] <= '0;
        end else if (error_correct_i[u] && (burst_q[u] != 8'hFF)) begin
          burst_q[u] <= burst_q[u] + 8'd1;
        end
      end
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_fault_o <= '0;
      uncorr_o     <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      perm_fault_o <= perm_set | (perm_fault_o & {NUM_UNITS{~sticky_clr_i}});
      uncorr_o     <= uncorr_any | (uncorr_o & ~sticky_clr_i);
      irq_o        <= (|perm_fault_o) | uncorr_o;
    end
  end

  // The captured value is the counter before this cycle's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o <= '0;
    end else if (rd_gnt_o) begin
      rd_data_o <= addr_ok ? cnt_q[rd_addr_i] : '0;
    end
  end

endmodule
